// File: rtl/mux4_sel.sv
// Next-PC selector: 4-to-1 word mux with a zero-latency output plus registered copies
// of the selected word and select code for debug and trace.
module mux4_sel #(
   parameter int unsigned      WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] In_1,
   input  logic [WIDTH-1:0] In_2,
   input  logic [WIDTH-1:0] In_3,
   input  logic [WIDTH-1:0] In_4,
   input  logic [1:0]       Sel,
   output logic [WIDTH-1:0] Out,
   output logic [WIDTH-1:0] Out_q,
   output logic [1:0]       Sel_q
);

   logic [WIDTH-1:0] sel_word;
   // Initialisers give a defined trace value before the first edge in simulation.
   logic [WIDTH-1:0] trace_out_q = RESET_VALUE;
   logic [1:0]       trace_sel_q = 2'b00;

   // An unknown select falls into default, so fetch proceeds with PC+4.
   always_comb begin
      sel_word = In_1;
      case (Sel)
         2'b00:   sel_word = In_1;
         2'b01:   sel_word = In_2;
         2'b10:   sel_word = In_3;
         2'b11:   sel_word = In_4;
         default: sel_word = In_1;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         trace_out_q <= RESET_VALUE;
         trace_sel_q <= 2'b00;
      end else begin
         trace_out_q <= sel_word;
         trace_sel_q <= Sel;
      end
   end

   assign Out   = sel_word;
   assign Out_q = trace_out_q;
   assign Sel_q = trace_sel_q;

endmodule

// File: tb/tb_mux4_sel.sv
// Self-checking bench for mux4_sel: directed cases plus randomized traffic compared
// against an array-indexed reference model with a one-entry history for the registers.
`timescale 1ns/1ps
module tb_mux4_sel;

   localparam int unsigned W     = 32;
   localparam logic [W-1:0] RST_V = 32'h0000_3000;

   logic         clk;
   logic         reset;
   logic [W-1:0] in_v [4];
   logic [1:0]   sel;
   logic [W-1:0] out;
   logic [W-1:0] out_q;
   logic [1:0]   sel_q;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: expected registered values.
   logic [W-1:0] m_out_q = RST_V;
   logic [1:0]   m_sel_q = 2'b00;

   mux4_sel #(
      .WIDTH       (W),
      .RESET_VALUE (RST_V)
   ) dut (
      .Clk   (clk),
      .Reset (reset),
      .In_1  (in_v[0]),
      .In_2  (in_v[1]),
      .In_3  (in_v[2]),
      .In_4  (in_v[3]),
      .Sel   (sel),
      .Out   (out),
      .Out_q (out_q),
      .Sel_q (sel_q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [W-1:0] model_out();
      if ($isunknown(sel)) return in_v[0];
      return in_v[sel];
   endfunction

   task automatic check_eq(input string tag, input logic [W-1:0] got,
                           input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge; the model captures what the DUT should sample at that edge.
   task automatic tick();
      if (reset) begin
         m_out_q = RST_V;
         m_sel_q = 2'b00;
      end else begin
         m_out_q = model_out();
         m_sel_q = sel;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_regs(input string tag);
      check_eq({tag, "_out_q"}, out_q, m_out_q);
      check_eq({tag, "_sel_q"}, {30'd0, sel_q}, {30'd0, m_sel_q});
   endtask

   initial begin
      logic [W-1:0] held;
      reset = 1'b0;
      sel   = 2'b00;
      in_v[0] = 32'h0000_3004;
      in_v[1] = 32'h0000_3010;
      in_v[2] = 32'h0040_0000;
      in_v[3] = 32'h0000_3100;

      // Before any edge: registers hold their initial values; static select, no edge.
      #0.5;
      check_regs("init");
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         #0.5;
         check_eq($sformatf("static_sel%0d", s), out, model_out());
      end
      check_eq("static_sel3_const", out, 32'h0000_3100);

      // Registered copy and between-edge behaviour.
      sel = 2'd2;
      tick();
      check_eq("reg_out_q", out_q, 32'h0040_0000);
      check_eq("reg_sel_q", {30'd0, sel_q}, 32'd2);
      sel = 2'd3;
      #1;
      check_eq("between_out", out, 32'h0000_3100);
      check_eq("between_out_q", out_q, 32'h0040_0000);
      tick();
      check_regs("next_edge");

      // Synchronous reset: registers forced, Out unaffected.
      reset = 1'b1;
      #1;
      check_eq("rst_out_pre", out, 32'h0000_3100);
      tick();
      check_eq("rst_out_q", out_q, 32'h0000_3000);
      check_eq("rst_sel_q", {30'd0, sel_q}, 32'd0);
      check_eq("rst_out", out, 32'h0000_3100);
      reset = 1'b0;

      // Unknown select bit must fall back to In_1.
      sel = 2'bx1;
      #1;
      check_eq("x_sel", out, model_out());
      sel = 2'b00;

      // Walking one on the selected input, then toggle the others.
      for (int i = 0; i < 4; i++) begin
         sel = 2'(i);
         for (int b = 0; b < W; b++) begin
            in_v[i] = 32'd1 << b;
            #1;
            check_eq($sformatf("walk_in%0d_b%0d", i + 1, b), out, 32'd1 << b);
         end
         held = out;
         for (int k = 0; k < 4; k++) begin
            if (k != i) in_v[k] = $urandom;
         end
         #1;
         check_eq($sformatf("other_toggle_in%0d", i + 1), out, held);
      end

      // Back-to-back select sequence: Out_q lags Out by one cycle.
      in_v[0] = 32'h0000_3004;
      in_v[1] = 32'h0000_3010;
      in_v[2] = 32'h0040_0000;
      in_v[3] = 32'h0000_3100;
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         #1;
         held = out;
         tick();
         check_eq($sformatf("b2b_lag%0d", s), out_q, held);
         check_regs($sformatf("b2b%0d", s));
      end

      // Randomized traffic with occasional reset.
      for (int n = 0; n < 300; n++) begin
         for (int k = 0; k < 4; k++) in_v[k] = $urandom;
         sel   = 2'($urandom_range(0, 3));
         reset = ($urandom_range(0, 7) == 0);
         #1;
         check_eq($sformatf("rnd%0d_out", n), out, model_out());
         tick();
         check_regs($sformatf("rnd%0d", n));
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
